// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy/state
// encoding and the all-zero NOP control used for bubbles.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t ST_EMPTY = 2'd0;
  localparam occ_t ST_ONE   = 2'd1;
  localparam occ_t ST_TWO   = 2'd2;

  // Replicated to CTRL_W by users so the NOP works for any control width.
  localparam logic NOP_CTRL_BIT = 1'b0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones
// instead of wrapping.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  output logic [W-1:0] COUNT
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (INC && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, stall,
// flush-to-bubble, optional 2-entry skid buffer and a stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUSY_WAIT,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCC,
  output logic [CNT_W-1:0]  STALL_CNT
);

  localparam logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{NOP_CTRL_BIT}};

  occ_t              state_q, state_d;
  logic              valid_q;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              stall_inc_s;

  assign in_fire_s  = IN_VALID & in_ready_s;
  assign out_fire_s = valid_q & OUT_READY & ~BUSY_WAIT;

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
      logic [DATA_W-1:0] s_data_q, s_data_d;

      // Ready comes only from registered state, breaking the OUT_READY path.
      assign in_ready_s = (state_q != ST_TWO) & ~BUSY_WAIT & RESET;

      // Two-entry next state: M always holds the oldest entry.
      always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (FLUSH) begin
          state_d  = ST_EMPTY;
          m_ctrl_d = NOP_CTRL;
        end else if (BUSY_WAIT) begin
          state_d = state_q;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_fire_s) begin
                state_d  = ST_ONE;
                m_ctrl_d = IN_CTRL;
                m_data_d = IN_DATA;
              end else begin
                state_d = ST_EMPTY;
              end
            end
            ST_ONE: begin
              if (in_fire_s && out_fire_s) begin
                m_ctrl_d = IN_CTRL;
                m_data_d = IN_DATA;
              end else if (in_fire_s) begin
                state_d  = ST_TWO;
                s_ctrl_d = IN_CTRL;
                s_data_d = IN_DATA;
              end else if (out_fire_s) begin
                state_d  = ST_EMPTY;
                m_ctrl_d = NOP_CTRL;
              end else begin
                state_d = ST_ONE;
              end
            end
            ST_TWO: begin
              if (out_fire_s) begin
                state_d  = ST_ONE;
                m_ctrl_d = s_ctrl_q;
                m_data_d = s_data_q;
              end else begin
                state_d = ST_TWO;
              end
            end
            default: begin
              state_d  = ST_EMPTY;
              m_ctrl_d = NOP_CTRL;
            end
          endcase
        end
      end

      // Skid entry register.
      always_ff @(posedge CLK) begin
        if (!RESET) begin
          s_ctrl_q <= NOP_CTRL;
          s_data_q <= {DATA_W{1'b0}};
        end else begin
          s_ctrl_q <= s_ctrl_d;
          s_data_q <= s_data_d;
        end
      end
    end else begin : g_single
      assign in_ready_s = (~valid_q | OUT_READY) & ~BUSY_WAIT & RESET;

      // Single-entry next state.
      always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        if (FLUSH) begin
          state_d  = ST_EMPTY;
          m_ctrl_d = NOP_CTRL;
        end else if (BUSY_WAIT) begin
          state_d = state_q;
        end else if (in_fire_s) begin
          state_d  = ST_ONE;
          m_ctrl_d = IN_CTRL;
          m_data_d = IN_DATA;
        end else if (out_fire_s) begin
          state_d  = ST_EMPTY;
          m_ctrl_d = NOP_CTRL;
        end else begin
          state_d = state_q;
        end
      end
    end
  endgenerate

  // Main entry, state and output-valid registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= ST_EMPTY;
      valid_q  <= 1'b0;
      m_ctrl_q <= NOP_CTRL;
      m_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      valid_q  <= (state_d != ST_EMPTY);
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
    end
  end

  // A flushed cycle is not a stall: the held entry is gone.
  assign stall_inc_s = valid_q & (~OUT_READY | BUSY_WAIT) & ~FLUSH;

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (stall_inc_s),
    .COUNT (STALL_CNT)
  );

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = valid_q;
  assign OUT_CTRL  = m_ctrl_q;
  assign OUT_DATA  = m_data_q;
  assign OCC       = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: DUT a is the skid variant (16-bit counter), DUT b the
// single-entry variant with a 4-bit counter for saturation.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_busy, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_ctrl, a_out_ctrl;
  logic [95:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  logic        b_busy, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_ctrl, b_out_ctrl;
  logic [95:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(1), .CNT_W(16)) dut_a (
    .CLK(clk), .RESET(rst_n), .BUSY_WAIT(a_busy), .FLUSH(a_flush),
    .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .IN_CTRL(a_in_ctrl), .IN_DATA(a_in_data),
    .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_CTRL(a_out_ctrl),
    .OUT_DATA(a_out_data), .OCC(a_occ), .STALL_CNT(a_stall)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(0), .CNT_W(4)) dut_b (
    .CLK(clk), .RESET(rst_n), .BUSY_WAIT(b_busy), .FLUSH(b_flush),
    .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_CTRL(b_in_ctrl), .IN_DATA(b_in_data),
    .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_CTRL(b_out_ctrl),
    .OUT_DATA(b_out_data), .OCC(b_occ), .STALL_CNT(b_stall)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_busy = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 8'hFF; a_in_data = 96'd5;
    b_busy = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_ctrl = 8'h00; b_in_data = 96'd0;
    #2;
    step(); step();
    check_eq("rst_valid", a_out_valid, 1'b0);
    check_eq("rst_ctrl", a_out_ctrl, 8'h00);
    check_eq("rst_occ", a_occ, 2'd0);
    check_eq("rst_stall", a_stall, 16'd0);
    check_eq("rst_in_ready", a_in_ready, 1'b0);
    check_eq("rst_b_stall", b_stall, 4'd0);
    rst_n = 1'b1; a_in_valid = 1'b0; #1;
    check_eq("post_rst_in_ready", a_in_ready, 1'b1);
    check_eq("post_rst_b_in_ready", b_in_ready, 1'b1);

    // Streaming on the skid variant.
    a_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1'b1; a_in_data = 96'(i); a_in_ctrl = 8'(i + 1);
      #1;
      check_eq("stream_in_ready", a_in_ready, 1'b1);
      step();
      check_eq("stream_data", a_out_data, 96'(i));
      check_eq("stream_ctrl", a_out_ctrl, 8'(i + 1));
      check_eq("stream_occ", a_occ, 2'd1);
    end
    a_in_valid = 1'b0;
    step();
    check_eq("stream_drain_occ", a_occ, 2'd0);
    check_eq("stream_drain_ctrl", a_out_ctrl, 8'h00);
    check_eq("stream_stall", a_stall, 16'd0);

    // Backpressure on the skid variant.
    a_in_valid = 1'b1; a_in_data = 96'd0; a_in_ctrl = 8'h10;
    step();
    a_out_ready = 1'b0; a_in_data = 96'd1; a_in_ctrl = 8'h11; #1;
    check_eq("bp_accept_extra", a_in_ready, 1'b1);
    step();
    a_in_data = 96'd2; a_in_ctrl = 8'h12; #1;
    check_eq("bp_occ2", a_occ, 2'd2);
    check_eq("bp_in_ready_low", a_in_ready, 1'b0);
    check_eq("bp_data_hold", a_out_data, 96'd0);
    step();
    check_eq("bp_data_hold2", a_out_data, 96'd0);
    a_out_ready = 1'b1; #1;
    check_eq("bp_ready_still_low", a_in_ready, 1'b0);
    step();
    check_eq("bp_emit1", a_out_data, 96'd1);
    check_eq("bp_occ1", a_occ, 2'd1);
    check_eq("bp_ready_back", a_in_ready, 1'b1);
    step();
    check_eq("bp_emit2", a_out_data, 96'd2);
    a_in_valid = 1'b0;
    step();
    check_eq("bp_empty", a_occ, 2'd0);
    check_eq("bp_stall", a_stall, 16'd2);

    // Flush with two entries held and a simultaneous offer.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 96'd8; a_in_ctrl = 8'h18;
    step();
    a_in_data = 96'd9; a_in_ctrl = 8'h19;
    step();
    check_eq("fl_occ2", a_occ, 2'd2);
    a_flush = 1'b1; a_in_data = 96'd7; a_in_ctrl = 8'h17;
    step();
    check_eq("fl_valid", a_out_valid, 1'b0);
    check_eq("fl_ctrl", a_out_ctrl, 8'h00);
    check_eq("fl_occ", a_occ, 2'd0);
    check_eq("fl_data_kept", a_out_data, 96'd8);
    a_flush = 1'b0; a_in_valid = 1'b0;
    step();
    check_eq("fl_no7_valid", a_out_valid, 1'b0);
    check_eq("fl_stall", a_stall, 16'd3);

    // BUSY_WAIT freeze for three cycles.
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 96'd20; a_in_ctrl = 8'h33;
    step();
    a_in_data = 96'd21; a_in_ctrl = 8'h34; a_busy = 1'b1; #1;
    check_eq("bw_in_ready", a_in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bw_data", a_out_data, 96'd20);
      check_eq("bw_ctrl", a_out_ctrl, 8'h33);
      check_eq("bw_valid", a_out_valid, 1'b1);
      check_eq("bw_occ", a_occ, 2'd1);
    end
    check_eq("bw_stall", a_stall, 16'd6);
    a_busy = 1'b0; a_in_valid = 1'b0;
    step();
    check_eq("bw_release_occ", a_occ, 2'd0);

    // BUSY_WAIT with FLUSH in its second cycle.
    a_in_valid = 1'b1; a_in_data = 96'd30; a_in_ctrl = 8'h30;
    step();
    a_in_valid = 1'b0; a_busy = 1'b1;
    step();
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    step();
    check_eq("bwf_occ", a_occ, 2'd0);
    check_eq("bwf_valid", a_out_valid, 1'b0);
    check_eq("bwf_ctrl", a_out_ctrl, 8'h00);
    check_eq("bwf_stall", a_stall, 16'd7);
    a_busy = 1'b0;

    // Single-entry variant: streaming.
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1; b_in_data = 96'(i + 40); b_in_ctrl = 8'(i + 2);
      #1;
      check_eq("b_stream_in_ready", b_in_ready, 1'b1);
      step();
      check_eq("b_stream_data", b_out_data, 96'(i + 40));
      check_eq("b_stream_occ", b_occ, 2'd1);
    end
    b_in_valid = 1'b0;
    step();
    check_eq("b_drain_occ", b_occ, 2'd0);

    // Single-entry backpressure and counter saturation over 20 stall cycles.
    b_in_valid = 1'b1; b_in_data = 96'd10; b_in_ctrl = 8'h0A;
    step();
    b_out_ready = 1'b0; b_in_data = 96'd11; b_in_ctrl = 8'h0B; #1;
    check_eq("b_bp_in_ready", b_in_ready, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("b_bp_occ", b_occ, 2'd1);
      check_eq("b_bp_data", b_out_data, 96'd10);
    end
    check_eq("b_sat", b_stall, 4'd15);
    b_out_ready = 1'b1; #1;
    check_eq("b_ready_comb", b_in_ready, 1'b1);
    step();
    check_eq("b_next_data", b_out_data, 96'd11);
    check_eq("b_next_ctrl", b_out_ctrl, 8'h0B);
    check_eq("b_sat_hold", b_stall, 4'd15);
    b_in_valid = 1'b0;
    step();
    check_eq("b_final_occ", b_occ, 2'd0);
    check_eq("b_final_ctrl", b_out_ctrl, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the RV32 pipeline, the successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary control and data payload across one stage boundary with a valid/ready handshake. It supports:

- global stall (BUSY_WAIT)
- flush-to-bubble (FLUSH)
- an optional 2-entry skid buffer that removes the combinational OUT_READY→IN_READY path
- a saturating stall-cycle counter for performance debug

## Interface
Parameters:
- CTRL_W, 8: control bits; forced to 0 on bubble, flush or reset.
- DATA_W, 96: data payload bits; not cleared by flush.
- SKID, 1: 0 = single entry with combinational ready; 1 = two entries with registered ready.
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-low reset, sampled on posedge CLK.
- BUSY_WAIT  in  1  global freeze (memory stall).
- FLUSH  in  1  discard all held entries (branch mispredict / trap).
- IN_VALID  in  1  upstream entry offered.
- IN_READY  out  1  stage can accept.
- IN_CTRL  in  CTRL_W  upstream control.
- IN_DATA  in  DATA_W  upstream data.
- OUT_VALID  out  1  entry presented downstream.
- OUT_READY  in  1  downstream accepts.
- OUT_CTRL  out  CTRL_W  registered control.
- OUT_DATA  out  DATA_W  registered data.
- OCC  out  2  entries held (0..2; never exceeds 1 when SKID=0).
- STALL_CNT  out  CNT_W  saturating count of output-stall cycles.

## Operation
- Transfer definitions:
  - in_fire = IN_VALID & IN_READY.
  - out_fire = OUT_VALID & OUT_READY & !BUSY_WAIT.
- Priority at each posedge: RESET low > FLUSH > BUSY_WAIT > normal handshake.
- Reset:
  - State EMPTY, OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, OCC=0, STALL_CNT=0.
  - IN_READY is 0 while RESET is low.
- FLUSH:
  - Next state EMPTY, OUT_VALID=0, OUT_CTRL=0. OUT_DATA and the skid data are unchanged.
  - An input offered in the same cycle is dropped.
  - FLUSH overrides BUSY_WAIT.
- BUSY_WAIT:
  - No state, payload or OCC change; IN_READY forced 0; OUT_VALID/OUT_CTRL/OUT_DATA held.
  - A held entry is not consumed even if OUT_READY=1.
- SKID=1 state machine (main register M drives the outputs; skid register S holds the overflow entry):
  - EMPTY:
    - in_fire → ONE (M←in).
  - ONE:
    - in_fire & out_fire → ONE (M←in).
    - in_fire & !out_fire → TWO (S←in).
    - !in_fire & out_fire → EMPTY.
    - Otherwise hold.
  - TWO:
    - out_fire → ONE (M←S).
    - in_fire is impossible because IN_READY=0.
  - IN_READY = (state≠TWO) & !BUSY_WAIT & RESET. It does not depend on OUT_READY.
- SKID=0: single register M.
  - IN_READY = (!OUT_VALID | OUT_READY) & !BUSY_WAIT & RESET.
  - in_fire loads M; out_fire without in_fire empties M.
  - S and the TWO state are not instantiated.
- Ordering is strictly FIFO; no entry is duplicated or lost except by FLUSH or RESET.
- OUT_CTRL is 0 whenever OUT_VALID=0.
- STALL_CNT:
  - Increments by 1 on each posedge with OUT_VALID & (!OUT_READY | BUSY_WAIT) and no FLUSH.
  - Saturates at 2^CNT_W−1; it never wraps.
  - Cleared only by reset.

## Timing
- Latency is 1 cycle: an entry accepted at edge N appears on OUT_* after edge N when the stage was EMPTY, or when in ONE with out_fire.
- Throughput is 1 entry/cycle with OUT_READY held high, in both modes.
- SKID=1:
  - After the first OUT_READY-low cycle, one more entry is still accepted; IN_READY drops the cycle after.
  - IN_READY reasserts the cycle after the first out_fire from TWO.
- All outputs are registered except IN_READY, which is a combinational function of the registered state, BUSY_WAIT and RESET (plus OUT_READY when SKID=0).
- Simultaneous FLUSH and out_fire: the downstream transfer counts as completed; the stage is still EMPTY afterwards.

## Structure
- Shared package pipe_pkg:
  - state encoding localparams: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2
  - the NOP control constant (all zeros) used for bubbles
- One sub-module, pipe_sat_counter (parameter W; ports CLK, RESET, INC, COUNT), reused by other stages' stall counters.
- Generate blocks select the SKID=0 or SKID=1 datapath.

## Test plan
- Reset: drive RESET=0 for 2 cycles with IN_VALID=1, IN_CTRL=8'hFF → OUT_VALID=0, OUT_CTRL=0, OCC=0, STALL_CNT=0, IN_READY=0; after release IN_READY=1.
- Streaming, SKID=1: 16 entries DATA=0..15, OUT_READY=1 → outputs 0..15 in order on consecutive cycles, OCC stays 1, STALL_CNT=0.
- Backpressure, SKID=1: stream 0,1,2 with OUT_READY=0 from cycle 1 → OCC reaches 2 and IN_READY falls; OUT_DATA stays 0. Raise OUT_READY → 1 emitted next, then 2; STALL_CNT matches the number of stalled cycles.
- Flush: with OCC=2, assert FLUSH together with IN_VALID (DATA=7) → next cycle OUT_VALID=0, OUT_CTRL=0, OCC=0; 7 never appears at the output.
- BUSY_WAIT: hold 3 cycles with OUT_READY=1, OUT_VALID=1 → outputs frozen, IN_READY=0, STALL_CNT +3. Repeat with FLUSH in cycle 2 → EMPTY.
- Saturation, CNT_W=4: stall 20 cycles → STALL_CNT=15, no wrap. SKID=0 variant: same streaming and backpressure scenarios, OCC never exceeds 1.
